// File: rtl/dump_trigger.sv
// dump_trigger: counts frames from an asynchronous active-low vsync and opens a
// dump window when a chosen frame number is reached. The block can be held idle
// while a ROM download is in progress.
// Optional feature: define FRAME_LIMIT_EN to close the window after LEN frames
// and park in DONE. Without it the window stays open until reset or a download.
module dump_trigger #(
    parameter int unsigned START_FRAME = 0,
    parameter logic [15:0] LEN         = 16'd16,
    parameter bit          WAIT_DL     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_n,
    input  logic        downloading,
    output logic [31:0] frame_cnt,
    output logic        frame_pls,
    output logic        dump_on,
    output logic        dump_start,
    output logic        dump_stop,
    output logic [1:0]  st
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam state_t RST_STATE = WAIT_DL ? IDLE : ARMED;

    state_t state;
    logic   vs_s1, vs_s2, vs_s3;
    logic   dl_q;
    logic   hold;
    logic   dl_fall;
    logic   edge_det;

    // Download only has an effect when the block is configured to wait for it.
    assign hold     = WAIT_DL && downloading;
    assign dl_fall  = WAIT_DL && dl_q && !downloading;
    // vs_s3 is the previous synchronised value; a 1->0 step is a frame edge.
    assign edge_det = vs_s3 && !vs_s2 && !hold;
    assign st       = state;

`ifdef FRAME_LIMIT_EN
    logic [15:0] win_cnt;
    logic        win_full;

    // The frame that opens the window is not counted; LEN=0 and LEN=1 both
    // close on the first frame after opening.
    assign win_full = ({1'b0, win_cnt} + 17'd1) >= {1'b0, LEN};
`else
    logic [15:0] len_unused;

    // LEN only matters when the window limit is built in.
    assign len_unused = LEN;
`endif

    // vsync synchroniser plus one history flop for edge detection; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
            vs_s3 <= 1'b1;
        end else begin
            vs_s1 <= vs_n;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    // Delayed downloading, used to find its falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dl_q <= 1'b0;
        else        dl_q <= downloading;
    end

    // Frame pulse and frame counter; the counter steps in the cycle after the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_pls <= 1'b0;
            frame_cnt <= 32'd0;
        end else if (hold) begin
            frame_pls <= 1'b0;
            frame_cnt <= 32'd0;
        end else begin
            frame_pls <= edge_det;
            if (frame_pls) frame_cnt <= frame_cnt + 32'd1;
        end
    end

    // Window state machine; decisions use edge_det so that dump_start lines up
    // with frame_pls and sees the pre-increment frame_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_STATE;
            dump_on    <= 1'b0;
            dump_start <= 1'b0;
            dump_stop  <= 1'b0;
`ifdef FRAME_LIMIT_EN
            win_cnt    <= 16'd0;
`endif
        end else begin
            dump_start <= 1'b0;
            dump_stop  <= 1'b0;
            if (hold) begin
                // A download always wins; closing an open window reports a stop.
                if (state == DUMP) dump_stop <= 1'b1;
                state   <= IDLE;
                dump_on <= 1'b0;
`ifdef FRAME_LIMIT_EN
                win_cnt <= 16'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (dl_fall) state <= ARMED;
                    end
                    ARMED: begin
                        if (edge_det && frame_cnt == 32'(START_FRAME)) begin
                            state      <= DUMP;
                            dump_on    <= 1'b1;
                            dump_start <= 1'b1;
`ifdef FRAME_LIMIT_EN
                            win_cnt    <= 16'd0;
`endif
                        end
                    end
                    DUMP: begin
`ifdef FRAME_LIMIT_EN
                        if (edge_det) begin
                            if (win_full) begin
                                state     <= DONE;
                                dump_on   <= 1'b0;
                                dump_stop <= 1'b1;
                            end else begin
                                win_cnt <= win_cnt + 16'd1;
                            end
                        end
`endif
                    end
                    default: ; // DONE is left only by reset or a download
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dump_trigger.sv
// tb_dump_trigger: directed checks of dump_trigger with START_FRAME=3, LEN=2,
// WAIT_DL=1. Inputs change on the falling clock edge and outputs are sampled
// on the falling edge, half a cycle away from the active edge.
module tb_dump_trigger;

    logic        clk;
    logic        rst_n;
    logic        vs_n;
    logic        downloading;
    logic [31:0] frame_cnt;
    logic        frame_pls;
    logic        dump_on;
    logic        dump_start;
    logic        dump_stop;
    logic [1:0]  st;

    int checks = 0;
    int errors = 0;
    int pls_seen = 0;

    dump_trigger #(
        .START_FRAME (3),
        .LEN         (16'd2),
        .WAIT_DL     (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vs_n        (vs_n),
        .downloading (downloading),
        .frame_cnt   (frame_cnt),
        .frame_pls   (frame_pls),
        .dump_on     (dump_on),
        .dump_start  (dump_start),
        .dump_stop   (dump_stop),
        .st          (st)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (frame_pls) pls_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive vsync low on a falling edge and wait for frame_pls. Latency counts
    // rising edges starting with the one that first samples vs_n low.
    task automatic frame_edge();
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        vs_n = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (frame_pls) seen = 1'b1;
        end
        check("pls_lat", lat, 3);
    endtask

    // Cycle after the pulse: pulse gone, counter stepped; then release vsync.
    task automatic frame_tail(input logic [31:0] cnt_exp);
        @(negedge clk);
        check("pls_one_cycle", frame_pls, 0);
        check("fcnt_post", frame_cnt, cnt_exp);
        check("dstart_one_cycle", dump_start, 0);
        vs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Pulse downloading for a few cycles and check the return to ARMED.
    task automatic download(input int cycles);
        downloading = 1'b1;
        repeat (cycles) @(negedge clk);
        check("dl_idle", st, 0);
        check("dl_fcnt0", frame_cnt, 0);
        downloading = 1'b0;
        @(negedge clk);
        check("dl_armed", st, 1);
    endtask

    // From ARMED with frame_cnt=0, run four frames to open the window.
    task automatic open_window();
        for (int k = 1; k <= 4; k++) begin
            frame_edge();
            check("open_dstart", dump_start, (k == 4) ? 1 : 0);
            frame_tail(k);
        end
        check("open_st", st, 2);
    endtask

    initial begin
        int base;
        int got_pls;
        rst_n       = 1'b0;
        vs_n        = 1'b1;
        downloading = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_fcnt", frame_cnt, 0);
        check("rst_pls", frame_pls, 0);
        check("rst_on", dump_on, 0);
        check("rst_start", dump_start, 0);
        check("rst_stop", dump_stop, 0);
        check("rst_st", st, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_st_idle", st, 0);

        // Download for 100 cycles with a vsync pulse inside; nothing counts
        downloading = 1'b1;
        got_pls = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 20) vs_n = 1'b0;
            if (i == 30) vs_n = 1'b1;
            @(negedge clk);
            if (frame_pls) got_pls++;
        end
        check("dl_pls_supp", got_pls, 0);
        check("dl_fcnt_hold", frame_cnt, 0);
        check("dl_st_idle", st, 0);
        downloading = 1'b0;
        check("fall_same_cycle", st, 0);
        @(negedge clk);
        check("fall_armed", st, 1);

        // Five frames; window opens on the 4th with frame_cnt=3
        base = pls_seen;
        for (int k = 1; k <= 5; k++) begin
            frame_edge();
            check("fcnt_pre", frame_cnt, k - 1);
            check("dstart", dump_start, (k == 4) ? 1 : 0);
            check("don", dump_on, (k >= 4) ? 1 : 0);
            check("st_run", st, (k >= 4) ? 2 : 1);
            check("dstop_run", dump_stop, 0);
            frame_tail(k);
        end
        check("fcnt_5", frame_cnt, 5);
        check("pls_count_5", pls_seen - base, 5);

        // Sixth frame: window closes only when the limit is built in
        frame_edge();
`ifdef FRAME_LIMIT_EN
        check("lim_stop", dump_stop, 1);
        check("lim_on", dump_on, 0);
        check("lim_st_done", st, 3);
        frame_tail(6);
        frame_edge();
        check("done_stays", st, 3);
        check("done_no_stop", dump_stop, 0);
        check("done_no_start", dump_start, 0);
        frame_tail(7);
`else
        check("nolim_stop", dump_stop, 0);
        check("nolim_on", dump_on, 1);
        check("nolim_st", st, 2);
        frame_tail(6);
`endif

        // Counter wrap from a preloaded all-ones value
        force dut.frame_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt;
        @(negedge clk);
        frame_edge();
        check("wrap_pre", frame_cnt, 32'hFFFF_FFFF);
        frame_tail(32'd0);

        // Download rise while in DUMP
        download(5);
        open_window();
        downloading = 1'b1;
        @(negedge clk);
        check("dlr_stop", dump_stop, 1);
        check("dlr_on", dump_on, 0);
        check("dlr_st", st, 0);
        check("dlr_fcnt", frame_cnt, 0);
        @(negedge clk);
        check("dlr_stop_once", dump_stop, 0);
        check("dlr_fcnt_next", frame_cnt, 0);
        downloading = 1'b0;
        @(negedge clk);
        check("dlr_rearm", st, 1);

        // Reset in the middle of DUMP
        open_window();
        check("pre_rst_on", dump_on, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_on", dump_on, 0);
        check("mid_rst_stop", dump_stop, 0);
        check("mid_rst_st", st, 0);
        check("mid_rst_fcnt", frame_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_stop", dump_stop, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_st", st, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
